// File: rtl/trace_capture.sv
// Retirement-trace capture buffer: arms on request, starts storing (pc, alu) pairs
// once the chosen PC retires, and drains them through a valid/ready read port.
module trace_capture #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] alu_in,
    input  logic            retire_valid,
    input  logic            arm,
    input  logic            clr,
    input  logic [XLEN-1:0] trig_pc,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_pc,
    output logic [XLEN-1:0] rd_alu,
    output logic [AW:0]     count,
    output logic            overflow,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FULL    = 2'd3
    } state_t;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    state_t              state_q, state_nxt;
    logic [AW-1:0]       wp_q, rp_q;
    logic [AW:0]         count_q;
    logic                overflow_q;
    logic [2*XLEN-1:0]   mem [DEPTH];

    logic push, pop, drop, trig_hit;

    // Read handshake: an entry transfers on any edge where rd_valid && rd_ready;
    // rd_valid never drops and the head never changes until that transfer happens.
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign trig_hit = retire_valid && (pc_in == trig_pc);

    always_comb begin
        state_nxt = state_q;
        push      = 1'b0;
        drop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (trig_hit) begin
                    push      = 1'b1;
                    state_nxt = (count_q == CNT_LAST && !pop) ? S_FULL : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (retire_valid) begin
                    push = 1'b1;
                    if (count_q == CNT_LAST && !pop) state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                // A pop in the same cycle still cannot make room for this sample.
                if (retire_valid) drop = 1'b1;
                if (pop) state_nxt = S_CAPTURE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    // Storage carries no reset; stale contents are never presented while count is 0.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wp_q] <= {pc_in, alu_in};
    end

    assign rd_pc    = mem[rp_q][2*XLEN-1:XLEN];
    assign rd_alu   = mem[rp_q][XLEN-1:0];
    assign count    = count_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: queue-based reference model checked every cycle,
// plus hand-computed literal checks at the key scenario points.
module tb_trace_capture;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic [XLEN-1:0] alu_in = '0;
  logic            retire_valid = 1'b0;
  logic            arm = 1'b0;
  logic            clr = 1'b0;
  logic [XLEN-1:0] trig_pc = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_alu;
  logic [AW:0]     count;
  logic            overflow;
  logic [1:0]      state;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_in(alu_in),
    .retire_valid(retire_valid), .arm(arm), .clr(clr), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_alu(rd_alu),
    .count(count), .overflow(overflow), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [2*XLEN-1:0] exp_q[$];
  bit m_armed = 1'b0;
  bit m_trig  = 1'b0;
  bit m_ovf   = 1'b0;

  function automatic int m_state();
    if (!m_armed) return 0;
    if (!m_trig) return 1;
    return (exp_q.size() == DEPTH) ? 3 : 2;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset || clr) begin
        exp_q.delete();
        m_armed = 1'b0;
        m_trig  = 1'b0;
        m_ovf   = 1'b0;
      end else begin
        bit do_pop, do_push, do_drop;
        do_pop  = rd_ready && (exp_q.size() > 0);
        do_push = 1'b0;
        do_drop = 1'b0;
        if (m_trig && retire_valid) begin
          if (exp_q.size() < DEPTH) do_push = 1'b1;
          else do_drop = 1'b1;
        end else if (m_armed && !m_trig && retire_valid && pc_in == trig_pc) begin
          do_push = 1'b1;
          m_trig  = 1'b1;
        end
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({pc_in, alu_in});
        if (do_drop) m_ovf = 1'b1;
        if (arm) m_armed = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("state", 64'(state), 64'(m_state()));
        check("count", 64'(count), 64'(exp_q.size()));
        check("rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (exp_q.size() > 0) begin
          check("rd_pc", 64'(rd_pc), 64'(exp_q[0][2*XLEN-1:XLEN]));
          check("rd_alu", 64'(rd_alu), 64'(exp_q[0][XLEN-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu);
    retire_valid = 1'b1;
    pc_in        = pc;
    alu_in       = alu;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [XLEN-1:0] tpc);
    trig_pc = tpc;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // reset held with clock running
    repeat (3) tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    chk_en = 1'b1;
    reset = 1'b1;
    tick();
    do_arm(32'h10);
    check("arm_state", 64'(state), 64'd1);

    // trigger on 0x10
    for (int i = 0; i < 8; i++) retire(32'(i * 4), 32'(i * 4 + 1));
    check("trig_count", 64'(count), 64'd4);
    check("trig_state", 64'(state), 64'd2);
    check("trig_head_pc", 64'(rd_pc), 64'h10);
    check("trig_head_alu", 64'(rd_alu), 64'h11);
    do_arm(32'h999);  // ignored while capturing
    check("arm_ignored", 64'(state), 64'd2);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", 64'(rd_pc), 64'(32'h10 + 4 * k));
      check("drain_alu", 64'(rd_alu), 64'(32'h11 + 4 * k));
      tick();
    end
    rd_ready = 1'b0;
    check("drain_empty", 64'(rd_valid), 64'd0);
    do_clr();

    // fill and overflow: trigger + 17 retirements
    do_arm(32'h100);
    for (int i = 0; i < 18; i++) retire(32'(32'h100 + 4 * i), 32'(32'h5000 + i));
    check("full_count", 64'(count), 64'd16);
    check("full_state", 64'(state), 64'd3);
    check("full_overflow", 64'(overflow), 64'd1);
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("full_rd_pc", 64'(rd_pc), 64'(32'h100 + 4 * k));
      tick();
    end
    rd_ready = 1'b0;
    check("full_drained", 64'(rd_valid), 64'd0);
    do_clr();
    check("clr_ovf", 64'(overflow), 64'd0);

    // concurrent push/pop at count 15, with pointer wrap
    do_arm(32'h2000);
    for (int i = 0; i < 15; i++) retire(32'(32'h2000 + 4 * i), 32'(32'h7000 + i));
    check("c15_count", 64'(count), 64'd15);
    rd_ready = 1'b1;
    for (int i = 15; i < 55; i++) retire(32'(32'h2000 + 4 * i), 32'(32'h7000 + i));
    rd_ready = 1'b0;
    check("conc_count", 64'(count), 64'd15);
    check("conc_state", 64'(state), 64'd2);
    check("conc_overflow", 64'(overflow), 64'd0);
    check("conc_head_pc", 64'(rd_pc), 64'(32'h2000 + 4 * 40));
    retire(32'h3000, 32'h3001);
    check("to_full_state", 64'(state), 64'd3);
    rd_ready = 1'b1;
    retire(32'h3004, 32'h3005);
    rd_ready = 1'b0;
    check("full_pop_state", 64'(state), 64'd2);
    check("full_pop_count", 64'(count), 64'd15);
    check("full_pop_ovf", 64'(overflow), 64'd1);
    do_clr();

    // clr during capture with 5 entries
    do_arm(32'h40);
    for (int i = 0; i < 5; i++) retire(32'(32'h40 + 4 * i), 32'(i));
    check("pre_clr_count", 64'(count), 64'd5);
    do_clr();
    check("clr_state", 64'(state), 64'd0);
    check("clr_count", 64'(count), 64'd0);
    check("clr_rd_valid", 64'(rd_valid), 64'd0);

    // async reset during capture with 5 entries
    do_arm(32'h40);
    for (int i = 0; i < 5; i++) retire(32'(32'h40 + 4 * i), 32'(i));
    reset = 1'b0;
    #1;
    check("async_state", 64'(state), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_overflow", 64'(overflow), 64'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("post_rst_state", 64'(state), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Retirement-trace capture buffer for the pipelined RISC-V core. It consumes the core's observable outputs, the program counter and ALU result, which the processor testbench only drives and watches. Capture is armed and triggered on a chosen PC, and the sampled pairs are stored in a FIFO. A valid/ready port reads them out, so traces can be checked in simulation or on hardware without a waveform viewer.

## Interface
- XLEN, 32, width of PC and ALU result
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width (derived; do not override)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- pc_in  in  XLEN  processor pc_out
- alu_in  in  XLEN  processor alu_result
- retire_valid  in  1  sample strobe; pc_in/alu_in meaningful this cycle
- arm  in  1  single-cycle request to arm capture
- clr  in  1  synchronous clear of buffer, flags, FSM
- trig_pc  in  XLEN  PC that starts capture
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_pc  out  XLEN  head entry PC
- rd_alu  out  XLEN  head entry ALU result
- count  out  AW+1  entries held, 0..DEPTH
- overflow  out  1  sticky; a sample was dropped
- state  out  2  FSM state code

## Operation
- Storage: DEPTH×(2·XLEN) array, write pointer wp, read pointer rp, both AW bits, wrap modulo DEPTH. count is a separate AW+1-bit register.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, FULL=3.
  - IDLE: samples ignored. arm → ARMED.
  - ARMED: retire_valid && pc_in==trig_pc → write that sample, go to CAPTURE (or FULL if the write makes count==DEPTH). Other samples are ignored.
  - CAPTURE: every retire_valid writes. A write that leaves count==DEPTH (no simultaneous pop) → FULL.
  - FULL: retire_valid samples are dropped and set overflow. Any pop → CAPTURE.
  - arm in ARMED/CAPTURE/FULL is ignored.
- clr takes priority over everything, in any state. It forces IDLE, wp=rp=0, count=0 and overflow=0. Array contents are don't-care.
- Push = write accepted (ARMED trigger or CAPTURE). Pop = rd_valid && rd_ready.
- count update: push only +1; pop only −1; push and pop together leave count unchanged.
- Simultaneous push and pop at count==DEPTH−1 in CAPTURE: both happen, and the FSM stays in CAPTURE.
- FULL with retire_valid and pop in the same cycle: the sample is dropped and overflow is set. The pop happens and the FSM goes to CAPTURE.
- Read side works in every state, including IDLE after capture stops.
  - rd_valid = (count != 0).
  - rd_pc/rd_alu = mem[rp], combinational from the array. Held stable while rd_valid && !rd_ready.
- pc_in==trig_pc is a full XLEN equality compare.

## Timing
- Reset (reset=0, async) sets state=IDLE, wp=rp=0, count=0, overflow=0, rd_valid=0. rd_pc/rd_alu are X/don't-care until the first write; the implementation may zero them.
- Push at edge N: the entry appears at the head and count increments from edge N. rd_valid rises the cycle after a push into an empty buffer, so write-to-read latency is 1 cycle.
- Pop at edge N: rp advances and the next entry is presented after edge N.
- Both state transitions and overflow update on the same edge as the triggering push/drop.
- Reset asserted mid-capture aborts immediately. All buffered entries are lost and no partial state survives deassertion.
- arm and clr are level-sampled each edge. Holding arm high only matters in IDLE.

## Test plan
- Reset: hold reset=0, toggle clk → state=0, count=0, rd_valid=0, overflow=0. Release reset and pulse arm → state=1 next cycle.
- Trigger: arm, trig_pc=0x10. Retire PCs 0x00,0x04,…,0x1C with alu=pc+1 → the FIFO holds 0x10,0x14,0x18,0x1C with alu 0x11..0x1D, count=4, state=2.
- Fill/overflow, DEPTH=16: trigger, then 17 retirements with rd_ready=0 → count=16, state=3, overflow=1. Reading 16 entries returns the first 16 samples in order; rd_valid=0 after the last.
- Concurrent push/pop at count=15, rd_ready=1 → count stays 15, state=2, overflow=0, no sample lost over 40 cycles. Also check wrap-around of wp/rp past 15→0.
- FULL with simultaneous pop+retire → sample dropped, overflow=1, state=2, count=15.
- clr during CAPTURE with count=5 → next cycle state=0, count=0, rd_valid=0, overflow=0. Asserting reset=0 mid-capture gives the same result asynchronously, before the next edge.
